// File: rtl/pipe_regfile_mp_pkg.sv
// Shared definitions for the pipelined CPU register file and its neighbours.
package pipe_regfile_mp_pkg;

    // Default datapath geometry of the CPU
    localparam int DEF_DW = 32;
    localparam int DEF_AW = 5;

    // Architectural zero register address
    localparam int REG_ZERO = 0;

    // Data-width zero word, reused by the pipeline stages
    localparam logic [DEF_DW-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/pipe_regfile_mp_bypass.sv
// Single read port: zero-register override, write-to-read bypass
// (port B ahead of port A, then storage) and busy qualification.
module rf_bypass_mux
    import pipe_regfile_mp_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] reg_data,
    input  logic          reg_busy,
    input  logic          wa_en,
    input  logic [AW-1:0] wa_addr,
    input  logic [DW-1:0] wa_data,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] rd_data,
    output logic          rd_busy
);

    logic is_zero;
    logic hit_a;
    logic hit_b;

    // Read-priority chain; a register written this cycle is ready because its data is bypassed
    always_comb begin
        is_zero = (ZERO_REG != 0) && (rd_addr == AW'(REG_ZERO));
        hit_a   = wa_en && (wa_addr == rd_addr);
        hit_b   = wb_en && (wb_addr == rd_addr);
        rd_data = reg_data;
        rd_busy = reg_busy && !(hit_a || hit_b);
        if (is_zero) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end else if (hit_b) begin
            rd_data = wb_data;
        end else if (hit_a) begin
            rd_data = wa_data;
        end
    end

endmodule

// File: rtl/pipe_regfile_mp.sv
// Multi-port register file: two write ports, NRD bypassed read ports,
// per-register busy scoreboard with issue marking and flush.
module pipe_regfile_mp
    import pipe_regfile_mp_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wa_en,
    input  logic [AW-1:0]     wa_addr,
    input  logic [DW-1:0]     wa_data,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DW-1:0]     wb_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic             wa_keep;
    logic             wb_keep;

    // Writes to the hard-wired zero register are discarded
    always_comb begin
        wa_keep = wa_en && !((ZERO_REG != 0) && (wa_addr == AW'(REG_ZERO)));
        wb_keep = wb_en && !((ZERO_REG != 0) && (wb_addr == AW'(REG_ZERO)));
    end

    // Storage: port B is applied last so it wins a same-address collision
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wa_keep) regs[wa_addr] <= wa_data;
            if (wb_keep) regs[wb_addr] <= wb_data;
        end
    end

    // Scoreboard next state: write-clear, then issue-set, then flush
    always_comb begin
        busy_next = busy;
        if (wa_en) busy_next[wa_addr] = 1'b0;
        if (wb_en) busy_next[wb_addr] = 1'b0;
        if (iss_en) busy_next[iss_addr] = 1'b1;
        if (flush) busy_next = '0;
        if (ZERO_REG != 0) busy_next[REG_ZERO] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rd_addr[p*AW +: AW];

        rf_bypass_mux #(
            .DW       (DW),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_mux (
            .rd_addr  (addr),
            .reg_data (regs[addr]),
            .reg_busy (busy[addr]),
            .wa_en    (wa_en),
            .wa_addr  (wa_addr),
            .wa_data  (wa_data),
            .wb_en    (wb_en),
            .wb_addr  (wb_addr),
            .wb_data  (wb_data),
            .rd_data  (rd_data[p*DW +: DW]),
            .rd_busy  (rd_busy[p])
        );
    end

endmodule
